// File: rtl/noc_rr_arbiter_n.sv
// Round-robin output-port arbiter for the NoC router.
// One instance per output port. The last-served requester gets the lowest
// priority. LOCK_MODE=1 holds the grant from head to tail flit so wormhole
// packets never interleave. LOCK_MODE=0 re-arbitrates after every accepted
// flit, or when the granted requester withdraws.
//
// Handshake: a flit moves when grant_valid & req[grant_idx] & out_ready.
// That condition is reported on xfer. It is the only combinational output.
// req, tail and out_ready reach the grant registers only through the arbiter
// next-state logic.
module noc_rr_arbiter_n #(
   parameter int N_PORTS   = 5,
   parameter bit LOCK_MODE = 1'b1,
   parameter int IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] tail,
   input  logic               out_ready,
   output logic [N_PORTS-1:0] grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               xfer
);

   // grant_valid is the state bit itself, so the FSM state is directly observable.
   typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

   state_t             state;
   logic [IDX_W-1:0]   last;      // last-served requester (lowest priority)
   logic               req_g;     // request of the granted port
   logic               tail_g;    // tail flag of the granted port
   logic               release_g; // current grant ends this cycle
   logic               found;
   logic [IDX_W-1:0]   win;

   assign grant_valid = (state == GRANTED);

   // grant is one-hot, so masking selects the granted port's bit without an index
   assign req_g  = |(req & grant);
   assign tail_g = |(tail & grant);
   assign xfer   = grant_valid & req_g & out_ready;

   // Release: tail accepted in lock mode; any accepted flit or a withdrawn request in flit mode
   assign release_g = LOCK_MODE ? (xfer & tail_g) : (xfer | ~req_g);

   // Scan req upward from last+1 with wrap; lower offsets overwrite, so the nearest one wins
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = N_PORTS; k >= 1; k--) begin
         if (req[(int'(last) + k) % N_PORTS]) begin
            found = 1'b1;
            win   = IDX_W'((int'(last) + k) % N_PORTS);
         end
      end
   end

   // Grant FSM: arbitrate when idle or on release, otherwise hold the current grant
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         last      <= IDX_W'(N_PORTS - 1);
      end else if ((state == IDLE) || release_g) begin
         if (found) begin
            state     <= GRANTED;
            grant     <= N_PORTS'(1) << win;
            grant_idx <= win;
            last      <= win;
         end else begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_noc_rr_arbiter_n.sv
// Directed bench for noc_rr_arbiter_n.
// The lock-mode instance (l) and the flit-mode instance (f) share clk and rst.
// Inputs change 1 time unit after the rising edge. Outputs are compared
// 1 time unit later, well away from the edge.
module tb_noc_rr_arbiter_n;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req_l, tail_l, grant_l;
   logic       rdy_l, gv_l, xfer_l;
   logic [2:0] idx_l;
   logic [4:0] req_f, tail_f, grant_f;
   logic       rdy_f, gv_f, xfer_f;
   logic [2:0] idx_f;

   int checks   = 0;
   int failures = 0;
   int xfer_cnt;

   logic [5:0] rdy_seq  = 6'b111001;
   logic [5:0] req1_seq = 6'b111011;
   logic [5:0] tail_seq = 6'b100000;
   logic [2:0] alt_seq [6] = '{3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd3};

   always #5 clk = ~clk;

   noc_rr_arbiter_n #(.N_PORTS(5), .LOCK_MODE(1'b1)) dut_l (
      .clk(clk), .rst(rst), .req(req_l), .tail(tail_l), .out_ready(rdy_l),
      .grant(grant_l), .grant_valid(gv_l), .grant_idx(idx_l), .xfer(xfer_l)
   );

   noc_rr_arbiter_n #(.N_PORTS(5), .LOCK_MODE(1'b0)) dut_f (
      .clk(clk), .rst(rst), .req(req_f), .tail(tail_f), .out_ready(rdy_f),
      .grant(grant_f), .grant_valid(gv_f), .grant_idx(idx_f), .xfer(xfer_f)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full compare of the lock-mode outputs against an expected grant index or idle
   task automatic chk_l(input string tag, input logic v, input logic [2:0] idx, input logic x);
      chk({tag, "_gv"}, gv_l, v);
      chk({tag, "_idx"}, idx_l, v ? idx : 3'd0);
      chk({tag, "_grant"}, grant_l, v ? (5'b00001 << idx) : 5'b00000);
      chk({tag, "_xfer"}, xfer_l, x);
   endtask

   task automatic chk_f(input string tag, input logic v, input logic [2:0] idx, input logic x);
      chk({tag, "_gv"}, gv_f, v);
      chk({tag, "_idx"}, idx_f, v ? idx : 3'd0);
      chk({tag, "_grant"}, grant_f, v ? (5'b00001 << idx) : 5'b00000);
      chk({tag, "_xfer"}, xfer_f, x);
   endtask

   initial begin
      rst = 1'b1;
      req_l = '0; tail_l = '0; rdy_l = 1'b0;
      req_f = '0; tail_f = '0; rdy_f = 1'b0;
      #1;
      tick();
      tick();

      // 1. idle after reset
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1 chk_l("t1_idle", 1'b0, 3'd0, 1'b0);
         tick();
      end

      // 2. all requesting: 0,1,2,3,4,0 back to back
      req_l = 5'b11111; tail_l = 5'b11111; rdy_l = 1'b1;
      #1 chk_l("t2_pre", 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_l($sformatf("t2_rr%0d", k), 1'b1, 3'(k % 5), 1'b1);
      end

      // port 0 ends its packet; ports 1 and 3 request, port 1 is next after 0
      req_l = 5'b01011; tail_l = 5'b00001;
      #1 chk_l("t3_p0tail", 1'b1, 3'd0, 1'b1);
      tick();

      // 3. packet lock: port 1 four flits with a 2-cycle stall, port 3 waiting
      xfer_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         req_l  = {3'b010, req1_seq[k], 1'b0};
         tail_l = {3'b010, tail_seq[k], 1'b0};
         rdy_l  = rdy_seq[k];
         #1 chk_l($sformatf("t3_lock%0d", k), 1'b1, 3'd1, rdy_seq[k] & req1_seq[k]);
         if (xfer_l) xfer_cnt++;
         tick();
      end
      chk("t3_xfer_count", xfer_cnt, 4);
      req_l = 5'b01100; tail_l = 5'b01000; rdy_l = 1'b1;
      #1 chk_l("t3_p3", 1'b1, 3'd3, 1'b1);
      tick();

      // 4. port 3 served, scan 4,0,1,2 -> port 2
      req_l = 5'b00101; tail_l = 5'b00100;
      #1 chk_l("t4_p2", 1'b1, 3'd2, 1'b1);
      tick();
      // after port 2, scan 3,4,0 -> port 0
      req_l = 5'b00101; tail_l = 5'b00001;
      #1 chk_l("t4_p0", 1'b1, 3'd0, 1'b1);
      tick();
      // port 0 just served: port 2 beats it despite the lower index of port 0
      req_l = 5'b00100; tail_l = 5'b00100;
      #1 chk_l("t4_p2b", 1'b1, 3'd2, 1'b1);
      tick();
      // sole requester regains the grant with no bubble
      req_l = 5'b10100; tail_l = 5'b00100;
      #1 chk_l("t4_regain", 1'b1, 3'd2, 1'b1);
      tick();

      // 6. reset during flit 2 of a port 4 packet
      req_l = 5'b10000; tail_l = 5'b00000;
      #1 chk_l("t6_p4f1", 1'b1, 3'd4, 1'b1);
      tick();
      rst = 1'b1;
      #1 chk_l("t6_p4f2", 1'b1, 3'd4, 1'b1);
      tick();
      rst = 1'b0; req_l = 5'b11111;
      #1 chk_l("t6_rst", 1'b0, 3'd0, 1'b0);
      tick();
      chk_l("t6_ptr", 1'b1, 3'd0, 1'b1);

      // 5. flit mode: ports 1 and 3 alternate every accepted flit
      rdy_f = 1'b1; tail_f = 5'b00000;
      req_f = 5'b01010;
      #1 chk_f("t5_pre", 1'b0, 3'd0, 1'b0);
      tick();
      for (int k = 0; k < 6; k++) begin
         req_f = (k == 5) ? 5'b01000 : 5'b01010;
         #1 chk_f($sformatf("t5_alt%0d", k), 1'b1, alt_seq[k], 1'b1);
         tick();
      end
      // port 3 alone regained; withdrawing with nothing else pending goes idle
      req_f = 5'b00000;
      #1 chk_f("t5_withdraw", 1'b1, 3'd3, 1'b0);
      tick();
      #1 chk_f("t5_idle", 1'b0, 3'd0, 1'b0);

      // withdrawal while stalled moves on; a stalled but held request keeps the grant
      req_f = 5'b00100;
      tick();
      req_f = 5'b10001; rdy_f = 1'b0;
      #1 chk_f("t5_p2", 1'b1, 3'd2, 1'b0);
      tick();
      #1 chk_f("t5_p4", 1'b1, 3'd4, 1'b0);
      tick();
      req_f = 5'b00000;
      #1 chk_f("t5_hold", 1'b1, 3'd4, 1'b0);
      tick();
      #1 chk_f("t5_none", 1'b0, 3'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
